// File: rtl/mac_accumulator_8bit_if.sv
// Valid/ready stream bundle for the MAC accumulator: product beats in, frame results out.
// The master side drives beats and result acceptance; the slave side is the accumulator.
interface mac_accumulator_8bit_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  logic             out_trunc;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf, out_trunc
  );
endinterface

// File: rtl/mac_accumulator_8bit.sv
// Frame accumulator behind the 8x8 multiplier array: sums 16-bit products until in_last
// or the beat limit, then holds the result. Define SATURATE_EN to clamp instead of wrap.
module mac_accumulator_8bit #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  mac_accumulator_8bit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             trunc_q, trunc_d;

  logic             in_ready;
  logic             accept;
  logic             first;
  logic             closing;
  logic             carry;
  logic             ovf_base;
  logic [ACC_W-1:0] base;
  logic [CNT_W-1:0] count_inc;
  logic [ACC_W:0]   sum_wide;

  assign in_ready      = (state_q != S_HOLD);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_trunc = trunc_q;

  // NOTE: every variable gets a default at the top of the block, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    trunc_d = trunc_q;

    // The first beat of a frame starts from an empty accumulator and a clean ovf flag.
    first     = (state_q == S_IDLE);
    base      = first ? '0 : acc_q;
    ovf_base  = first ? 1'b0 : ovf_q;
    count_inc = first ? CNT_W'(1) : count_q + CNT_W'(1);
    sum_wide  = {1'b0, base} + (ACC_W+1)'(bus.in_p);
    carry     = sum_wide[ACC_W];
    closing   = bus.in_last || (count_inc == {CNT_W{1'b1}});

    unique case (state_q)
      S_IDLE, S_ACC: begin
        if (accept) begin
`ifdef SATURATE_EN
          acc_d = (carry || ovf_base) ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
          acc_d = sum_wide[ACC_W-1:0];
`endif
          count_d = count_inc;
          ovf_d   = ovf_base || carry;
          trunc_d = closing && !bus.in_last;
          state_d = closing ? S_HOLD : S_ACC;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over both a beat acceptance and a result handshake in the same cycle.
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      trunc_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together
  // from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      trunc_q <= trunc_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator_8bit.sv
// Self-checking bench for mac_accumulator_8bit: directed frame scenarios plus random
// frames scored against a frame-level arithmetic model.
module tb_mac_accumulator_8bit;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mac_accumulator_8bit_if #(.ACC_W(24), .CNT_W(8)) bus_main ();
  mac_accumulator_8bit_if #(.ACC_W(17), .CNT_W(8)) bus_ovf ();
  mac_accumulator_8bit_if #(.ACC_W(24), .CNT_W(2)) bus_lim ();

  mac_accumulator_8bit #(.ACC_W(24), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_main));
  mac_accumulator_8bit #(.ACC_W(17), .CNT_W(8)) u_ovf (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_ovf));
  mac_accumulator_8bit #(.ACC_W(24), .CNT_W(2)) u_lim (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_lim));

  // Offers one beat to the main instance and returns just after the edge that took it.
  task automatic send_beat(input logic [15:0] p, input logic last);
    bit taken = 0;
    bus_main.in_valid = 1'b1;
    bus_main.in_p     = p;
    bus_main.in_last  = last;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = bus_main.in_ready;
      @(posedge clk); #1;
    end
    checks++;
    if (!taken) begin
      failures++;
      $display("FAIL send_beat_timeout: beat %h never accepted", p);
    end
    bus_main.in_valid = 1'b0;
    bus_main.in_p     = 'x;
    bus_main.in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus_main.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", bus_main.out_valid); end
    checks++; if (bus_main.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b want 1", bus_main.in_ready); end
    checks++; if (bus_main.out_sum !== 24'h0) begin failures++; $display("FAIL rst_sum: got %h want 0", bus_main.out_sum); end
    checks++; if ({bus_main.out_count, bus_main.out_ovf, bus_main.out_trunc} !== 10'h0) begin
      failures++; $display("FAIL rst_flags: got cnt=%0d ovf=%b trunc=%b want 0", bus_main.out_count, bus_main.out_ovf, bus_main.out_trunc);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    // Park a result in HOLD, then pull reset between edges.
    bus_main.out_ready = 1'b0;
    send_beat(16'h0100, 1'b0);
    send_beat(16'h0200, 1'b1);
    checks++; if (bus_main.out_valid !== 1'b1 || bus_main.out_sum !== 24'h000300) begin
      failures++; $display("FAIL rst_pre_hold: got valid=%b sum=%h want 1/000300", bus_main.out_valid, bus_main.out_sum);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_main.out_valid !== 1'b0 || bus_main.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_async_hs: got valid=%b ready=%b want 0/1", bus_main.out_valid, bus_main.in_ready);
    end
    checks++; if (bus_main.out_sum !== 24'h0 || bus_main.out_count !== 8'h0 || bus_main.out_trunc !== 1'b0) begin
      failures++; $display("FAIL rst_async_data: got sum=%h cnt=%0d trunc=%b want 0", bus_main.out_sum, bus_main.out_count, bus_main.out_trunc);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_main.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready: got %b want 1", bus_main.in_ready); end
    bus_main.out_ready = 1'b1;
  endtask

  task automatic test_frame();
    bus_main.out_ready = 1'b1;
    send_beat(16'h0006, 1'b0);
    send_beat(16'h00FF, 1'b0);
    checks++; if (bus_main.out_valid !== 1'b0) begin failures++; $display("FAIL frame_early_valid: got %b want 0", bus_main.out_valid); end
    send_beat(16'hFE01, 1'b1);
    checks++; if (bus_main.out_valid !== 1'b1) begin failures++; $display("FAIL frame_valid: got %b want 1", bus_main.out_valid); end
    checks++; if (bus_main.out_sum !== 24'h00FF06) begin failures++; $display("FAIL frame_sum: got %h want 00ff06", bus_main.out_sum); end
    checks++; if (bus_main.out_count !== 8'd3 || bus_main.out_ovf !== 1'b0 || bus_main.out_trunc !== 1'b0) begin
      failures++; $display("FAIL frame_meta: got cnt=%0d ovf=%b trunc=%b want 3/0/0", bus_main.out_count, bus_main.out_ovf, bus_main.out_trunc);
    end
    @(posedge clk); #1;
    checks++; if (bus_main.out_valid !== 1'b0 || bus_main.in_ready !== 1'b1) begin
      failures++; $display("FAIL frame_release: got valid=%b ready=%b want 0/1", bus_main.out_valid, bus_main.in_ready);
    end
  endtask

  task automatic test_backpressure();
    bus_main.out_ready = 1'b0;
    send_beat(16'h0101, 1'b0);
    send_beat(16'h0202, 1'b1);
    // A pending single-beat frame must not slip in while the result is held.
    bus_main.in_valid = 1'b1;
    bus_main.in_p     = 16'h1234;
    bus_main.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus_main.out_valid !== 1'b1 || bus_main.in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1/0", i, bus_main.out_valid, bus_main.in_ready);
      end
      checks++; if (bus_main.out_sum !== 24'h000303 || bus_main.out_count !== 8'd2) begin
        failures++; $display("FAIL bp_stable_%0d: got sum=%h cnt=%0d want 000303/2", i, bus_main.out_sum, bus_main.out_count);
      end
      @(posedge clk); #1;
    end
    bus_main.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus_main.out_valid !== 1'b0 || bus_main.in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_after_hs: got valid=%b ready=%b want 0/1", bus_main.out_valid, bus_main.in_ready);
    end
    bus_main.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_main.in_valid = 1'b0;
    bus_main.in_last  = 1'b0;
    checks++; if (bus_main.out_valid !== 1'b1 || bus_main.out_sum !== 24'h001234 || bus_main.out_count !== 8'd1) begin
      failures++; $display("FAIL bp_single_beat: got valid=%b sum=%h cnt=%0d want 1/001234/1", bus_main.out_valid, bus_main.out_sum, bus_main.out_count);
    end
    bus_main.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    bus_main.out_ready = 1'b1;
    send_beat(16'h0005, 1'b0);
    send_beat(16'h0007, 1'b0);
    bus_main.in_valid = 1'b1;
    bus_main.in_p     = 16'h0777;
    bus_main.in_last  = 1'b1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    bus_main.in_valid = 1'b0;
    bus_main.in_last  = 1'b0;
    checks++; if (bus_main.out_valid !== 1'b0 || bus_main.in_ready !== 1'b1 || bus_main.out_count !== 8'd0) begin
      failures++; $display("FAIL clr_acc: got valid=%b ready=%b cnt=%0d want 0/1/0", bus_main.out_valid, bus_main.in_ready, bus_main.out_count);
    end
    send_beat(16'h0010, 1'b1);
    checks++; if (bus_main.out_valid !== 1'b1 || bus_main.out_sum !== 24'h000010 || bus_main.out_count !== 8'd1) begin
      failures++; $display("FAIL clr_next_frame: got valid=%b sum=%h cnt=%0d want 1/000010/1", bus_main.out_valid, bus_main.out_sum, bus_main.out_count);
    end
    @(posedge clk); #1;
    bus_main.out_ready = 1'b0;
    send_beat(16'h0020, 1'b1);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++; if (bus_main.out_valid !== 1'b0 || bus_main.out_sum !== 24'h0) begin
      failures++; $display("FAIL clr_hold: got valid=%b sum=%h want 0/000000", bus_main.out_valid, bus_main.out_sum);
    end
    bus_main.out_ready = 1'b1;
  endtask

  task automatic test_overflow();
    logic [16:0] want_sum;
`ifdef SATURATE_EN
    want_sum = 17'h1FFFF;
`else
    want_sum = 17'h0FFFD;
`endif
    bus_ovf.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_ovf.in_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready_%0d: got %b want 1", i, bus_ovf.in_ready); end
      bus_ovf.in_valid = 1'b1;
      bus_ovf.in_p     = 16'hFFFF;
      bus_ovf.in_last  = (i == 2);
      @(posedge clk); #1;
    end
    bus_ovf.in_valid = 1'b0;
    bus_ovf.in_last  = 1'b0;
    checks++; if (bus_ovf.out_valid !== 1'b1 || bus_ovf.out_ovf !== 1'b1) begin
      failures++; $display("FAIL ovf_flag: got valid=%b ovf=%b want 1/1", bus_ovf.out_valid, bus_ovf.out_ovf);
    end
    checks++; if (bus_ovf.out_sum !== want_sum || bus_ovf.out_count !== 8'd3) begin
      failures++; $display("FAIL ovf_sum: got sum=%h cnt=%0d want %h/3", bus_ovf.out_sum, bus_ovf.out_count, want_sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_limit();
    bus_lim.out_ready = 1'b1;
    bus_lim.in_valid  = 1'b1;
    bus_lim.in_p      = 16'h0001;
    bus_lim.in_last   = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus_lim.out_valid !== 1'b1 || bus_lim.out_count !== 2'd3 || bus_lim.out_trunc !== 1'b1) begin
      failures++; $display("FAIL lim_close: got valid=%b cnt=%0d trunc=%b want 1/3/1", bus_lim.out_valid, bus_lim.out_count, bus_lim.out_trunc);
    end
    checks++; if (bus_lim.out_sum !== 24'h3 || bus_lim.in_ready !== 1'b0) begin
      failures++; $display("FAIL lim_sum: got sum=%h ready=%b want 000003/0", bus_lim.out_sum, bus_lim.in_ready);
    end
    @(posedge clk); #1;
    checks++; if (bus_lim.out_valid !== 1'b0 || bus_lim.in_ready !== 1'b1) begin
      failures++; $display("FAIL lim_release: got valid=%b ready=%b want 0/1", bus_lim.out_valid, bus_lim.in_ready);
    end
    @(posedge clk); #1;
    bus_lim.in_last = 1'b1;
    @(posedge clk); #1;
    bus_lim.in_valid = 1'b0;
    bus_lim.in_last  = 1'b0;
    checks++; if (bus_lim.out_valid !== 1'b1 || bus_lim.out_sum !== 24'h2 || bus_lim.out_count !== 2'd2 || bus_lim.out_trunc !== 1'b0) begin
      failures++; $display("FAIL lim_new_frame: got valid=%b sum=%h cnt=%0d trunc=%b want 1/000002/2/0",
                           bus_lim.out_valid, bus_lim.out_sum, bus_lim.out_count, bus_lim.out_trunc);
    end
    @(posedge clk); #1;
  endtask

  // Random frames with random gaps and backpressure, scored frame by frame.
  task automatic test_random();
    logic [15:0] beat_p[$];
    bit          beat_last[$];
    logic [23:0] exp_sum[$];
    int          exp_cnt[$];
    bit          exp_ovf[$];
    bit          exp_trunc[$];
    longint      cur_sum = 0;
    int          cur_cnt = 0;
    int          idx = 0;
    int          cyc = 0;
    bit          acc_ok, hs_ok, v;

    for (int f = 0; f < 40; f++) begin
      int len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        beat_p.push_back(16'($urandom));
        beat_last.push_back(b == len - 1);
      end
    end

    while ((idx < beat_p.size() || exp_sum.size() > 0) && cyc < 3000) begin
      v = (idx < beat_p.size()) && ($urandom_range(3) != 0);
      bus_main.in_valid  = v;
      bus_main.in_p      = v ? beat_p[idx] : 'x;
      bus_main.in_last   = v ? beat_last[idx] : 1'b0;
      bus_main.out_ready = 1'($urandom_range(1));
      @(negedge clk);
      checks++; if (bus_main.out_valid !== (exp_sum.size() > 0)) begin
        failures++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, bus_main.out_valid, exp_sum.size() > 0);
      end
      checks++; if (bus_main.in_ready !== (exp_sum.size() == 0)) begin
        failures++; $display("FAIL rnd_ready@%0d: got %b want %b", cyc, bus_main.in_ready, exp_sum.size() == 0);
      end
      if (bus_main.out_valid === 1'b1 && exp_sum.size() > 0) begin
        checks++; if (bus_main.out_sum !== exp_sum[0] || bus_main.out_count !== 8'(exp_cnt[0]) ||
                      bus_main.out_ovf !== exp_ovf[0] || bus_main.out_trunc !== exp_trunc[0]) begin
          failures++; $display("FAIL rnd_result@%0d: got sum=%h cnt=%0d ovf=%b trunc=%b want %h/%0d/%b/%b", cyc,
                               bus_main.out_sum, bus_main.out_count, bus_main.out_ovf, bus_main.out_trunc,
                               exp_sum[0], exp_cnt[0], exp_ovf[0], exp_trunc[0]);
        end
      end
      acc_ok = bus_main.in_valid && bus_main.in_ready;
      hs_ok  = bus_main.out_valid && bus_main.out_ready;
      @(posedge clk); #1;
      if (hs_ok && exp_sum.size() > 0) begin
        void'(exp_sum.pop_front()); void'(exp_cnt.pop_front());
        void'(exp_ovf.pop_front()); void'(exp_trunc.pop_front());
      end
      if (acc_ok) begin
        cur_sum += longint'(beat_p[idx]);
        cur_cnt++;
        if (beat_last[idx] || cur_cnt == 255) begin
          exp_sum.push_back(24'(cur_sum % (64'd1 << 24)));
          exp_cnt.push_back(cur_cnt);
          exp_ovf.push_back(cur_sum >= (64'd1 << 24));
          exp_trunc.push_back(!beat_last[idx]);
          cur_sum = 0;
          cur_cnt = 0;
        end
        idx++;
      end
      cyc++;
    end
    bus_main.in_valid  = 1'b0;
    bus_main.in_last   = 1'b0;
    bus_main.out_ready = 1'b1;
    checks++; if (cyc >= 3000) begin
      failures++; $display("FAIL rnd_timeout: got %0d beats left want 0", beat_p.size() - idx);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    bus_main.in_valid = 1'b0; bus_main.in_p = '0; bus_main.in_last = 1'b0; bus_main.out_ready = 1'b0;
    bus_ovf.in_valid  = 1'b0; bus_ovf.in_p  = '0; bus_ovf.in_last  = 1'b0; bus_ovf.out_ready  = 1'b0;
    bus_lim.in_valid  = 1'b0; bus_lim.in_p  = '0; bus_lim.in_last  = 1'b0; bus_lim.out_ready  = 1'b0;
    test_reset();
    test_frame();
    test_backpressure();
    test_clr();
    test_overflow();
    test_limit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
